// File: rtl/sdram_arbiter_if.sv
// Avalon-MM bundle between two requesters, the arbiter and the shared SDRAM slave port.
// The arbiter uses the slave modport; the requester/SDRAM side uses the master modport.
interface sdram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] m0_address;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] s_address;
  logic              s_read;
  logic              s_write;
  logic [DATA_W-1:0] s_writedata;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;

  modport slave (
    input  m0_address, m0_read, m0_write, m0_writedata,
    input  m1_address, m1_read, m1_write, m1_writedata,
    input  s_waitrequest, s_readdata, s_readdatavalid,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output s_address, s_read, s_write, s_writedata
  );

  modport master (
    output m0_address, m0_read, m0_write, m0_writedata,
    output m1_address, m1_read, m1_write, m1_writedata,
    output s_waitrequest, s_readdata, s_readdatavalid,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  s_address, s_read, s_write, s_writedata
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM slave port between two requesters,
// one transaction (write, or read plus its data return) in flight at a time.
module sdram_arbiter (
  input  logic                clk,
  input  logic                rst,
  sdram_arbiter_if.slave      bus,
  output logic [1:0]          grant,
  output logic                busy
);

  typedef enum logic [1:0] {StArb, StXfer, StRdWait} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   req0, req1;
  logic   own_read, own_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StArb;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign req0      = bus.m0_read | bus.m0_write;
  assign req1      = bus.m1_read | bus.m1_write;
  assign own_read  = owner_q ? bus.m1_read  : bus.m0_read;
  assign own_write = owner_q ? bus.m1_write : bus.m0_write;

  always_comb begin
    state_d              = state_q;
    owner_d              = owner_q;
    last_d               = last_q;
    bus.s_address        = '0;
    bus.s_writedata      = '0;
    bus.s_read           = 1'b0;
    bus.s_write          = 1'b0;
    bus.m0_waitrequest   = 1'b1;
    bus.m1_waitrequest   = 1'b1;
    bus.m0_readdatavalid = 1'b0;
    bus.m1_readdatavalid = 1'b0;

    case (state_q)
      StArb: begin
        if (req0 | req1) begin
          // On a tie the requester not served last wins.
          owner_d = (req0 & req1) ? ~last_q : req1;
          state_d = StXfer;
        end
      end
      StXfer: begin
        bus.s_address   = owner_q ? bus.m1_address   : bus.m0_address;
        bus.s_writedata = owner_q ? bus.m1_writedata : bus.m0_writedata;
        bus.s_read      = own_read;
        // Simultaneous read and write is illegal; it is served as a read.
        bus.s_write     = own_write & ~own_read;
        if (owner_q) bus.m1_waitrequest = bus.s_waitrequest;
        else         bus.m0_waitrequest = bus.s_waitrequest;
        if (bus.s_read && !bus.s_waitrequest) begin
          state_d = StRdWait;
        end else if (bus.s_write && !bus.s_waitrequest) begin
          last_d  = owner_q;
          state_d = StArb;
        end else if (!own_read && !own_write) begin
          state_d = StArb;
        end
      end
      StRdWait: begin
        if (bus.s_readdatavalid) begin
          bus.m0_readdatavalid = ~owner_q;
          bus.m1_readdatavalid = owner_q;
          last_d               = owner_q;
          state_d              = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  assign bus.m0_readdata = bus.s_readdata;
  assign bus.m1_readdata = bus.s_readdata;

  assign busy  = (state_q != StArb);
  assign grant = (state_q == StArb) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed scenarios plus a randomized two-master / one-slave run scored against a
// transaction-level model (reference memory, per-master request queues, fairness rule).
module tb_sdram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       busy;
  int         tests = 0;
  int         fails = 0;

  sdram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sdram_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.m0_address = '0; bus.m0_read = 1'b0; bus.m0_write = 1'b0; bus.m0_writedata = '0;
    bus.m1_address = '0; bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_writedata = '0;
    bus.s_waitrequest = 1'b1; bus.s_readdata = '0; bus.s_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.m0_write = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant got=%b exp=00", grant); end
    tests++;
    if (bus.s_write !== 1'b0) begin fails++; $display("FAIL reset_s_write got=%b exp=0", bus.s_write); end
    tests++;
    if (bus.m0_waitrequest !== 1'b1) begin
      fails++; $display("FAIL reset_m0_wait got=%b exp=1", bus.m0_waitrequest);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int n = 0;
    do_reset();
    bus.m0_address = 32'h100; bus.m0_writedata = 32'hCAFEF00D; bus.m0_write = 1'b1;
    for (int c = 0; c < 12 && n < 4; c++) begin
      @(posedge clk); #1;
      if (bus.s_write) begin
        n++;
        bus.s_waitrequest = (n <= 3);
        #1;
        tests++;
        if (bus.s_address !== 32'h100 || bus.s_writedata !== 32'hCAFEF00D) begin
          fails++;
          $display("FAIL wr_fields got=%h/%h exp=00000100/cafef00d", bus.s_address, bus.s_writedata);
        end
        tests++;
        if (bus.m0_waitrequest !== (n <= 3)) begin
          fails++; $display("FAIL wr_m0_wait cyc=%0d got=%b exp=%b", n, bus.m0_waitrequest, n <= 3);
        end
      end
    end
    tests++;
    if (n !== 4) begin fails++; $display("FAIL wr_hold_cycles got=%0d exp=4", n); end
    @(posedge clk); #1;
    bus.m0_write = 1'b0; bus.s_waitrequest = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || bus.s_write !== 1'b0) begin
      fails++; $display("FAIL wr_done got busy=%b s_write=%b exp=0/0", busy, bus.s_write);
    end
  endtask

  task automatic test_single_read();
    bit acc = 1'b0;
    int p0 = 0, p1 = 0;
    do_reset();
    bus.m1_address = 32'h200; bus.m1_read = 1'b1; bus.s_waitrequest = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(posedge clk); #1;
      if (bus.s_read) acc = 1'b1;
    end
    tests++;
    if (!acc || bus.s_address !== 32'h200) begin
      fails++; $display("FAIL rd_issue got acc=%b addr=%h exp=1/00000200", acc, bus.s_address);
    end
    @(posedge clk); #1;
    bus.m1_read = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      bus.s_readdatavalid = (k == 5);
      bus.s_readdata      = (k == 5) ? 32'h12345678 : $urandom;
      #1;
      if (bus.m0_readdatavalid) p0++;
      if (bus.m1_readdatavalid) begin
        p1++;
        tests++;
        if (bus.m1_readdata !== 32'h12345678) begin
          fails++; $display("FAIL rd_data got=%h exp=12345678", bus.m1_readdata);
        end
      end
      @(posedge clk); #1;
    end
    bus.s_readdatavalid = 1'b0;
    tests++;
    if (p1 !== 1) begin fails++; $display("FAIL rd_m1_pulses got=%0d exp=1", p1); end
    tests++;
    if (p0 !== 0) begin fails++; $display("FAIL rd_m0_pulses got=%0d exp=0", p0); end
  endtask

  task automatic test_contention();
    int k = 0;
    logic [1:0] exp_g;
    do_reset();
    bus.m0_address = 32'h10; bus.m0_writedata = 32'hA0A0A0A0; bus.m0_write = 1'b1;
    bus.m1_address = 32'h20; bus.m1_writedata = 32'hB1B1B1B1; bus.m1_write = 1'b1;
    bus.s_waitrequest = 1'b0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      @(posedge clk); #1;
      if (grant != 2'b00) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        tests++;
        if (grant !== exp_g) begin
          fails++; $display("FAIL contention_grant idx=%0d got=%b exp=%b", k, grant, exp_g);
        end
        k++;
      end
    end
    tests++;
    if (k !== 8) begin fails++; $display("FAIL contention_count got=%0d exp=8", k); end
    clear_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    bus.s_readdatavalid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL spur_arb got rdv=%b%b busy=%b exp=00/0",
                 bus.m1_readdatavalid, bus.m0_readdatavalid, busy);
      end
    end
    bus.m0_address = 32'h44; bus.m0_write = 1'b1; bus.s_waitrequest = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0 || grant !== 2'b01) begin
        fails++;
        $display("FAIL spur_xfer got rdv=%b%b grant=%b exp=00/01",
                 bus.m1_readdatavalid, bus.m0_readdatavalid, grant);
      end
    end
    bus.s_readdatavalid = 1'b0; bus.s_waitrequest = 1'b0;
    @(posedge clk); #1;
    bus.m0_write = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL spur_done got busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_rdwait();
    bit acc = 1'b0;
    do_reset();
    bus.m0_address = 32'h300; bus.m0_read = 1'b1; bus.s_waitrequest = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(posedge clk); #1;
      if (bus.s_read) acc = 1'b1;
    end
    @(posedge clk); #1;
    bus.m0_read = 1'b0;
    #1;
    tests++;
    if (!acc || busy !== 1'b1) begin
      fails++; $display("FAIL rstrd_pending got acc=%b busy=%b exp=1/1", acc, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.s_readdatavalid = 1'b1; bus.s_readdata = 32'hDEAD0001;
    #1;
    tests++;
    if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstrd_drop got rdv=%b%b busy=%b exp=00/0",
               bus.m1_readdatavalid, bus.m0_readdatavalid, busy);
    end
    @(posedge clk); #1;
    bus.s_readdatavalid = 1'b0;
    acc = 1'b0;
    bus.m1_address = 32'h400; bus.m1_read = 1'b1;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(posedge clk); #1;
      if (bus.s_read) acc = 1'b1;
    end
    tests++;
    if (!acc || bus.s_address !== 32'h400 || grant !== 2'b10) begin
      fails++;
      $display("FAIL rstrd_next_issue got acc=%b addr=%h grant=%b exp=1/00000400/10",
               acc, bus.s_address, grant);
    end
    @(posedge clk); #1;
    bus.m1_read = 1'b0; bus.s_readdatavalid = 1'b1; bus.s_readdata = 32'hBEEF0002;
    #1;
    tests++;
    if (bus.m1_readdatavalid !== 1'b1 || bus.m0_readdatavalid !== 1'b0 ||
        bus.m1_readdata !== 32'hBEEF0002) begin
      fails++;
      $display("FAIL rstrd_next_data got rdv=%b%b data=%h exp=10/beef0002",
               bus.m1_readdatavalid, bus.m0_readdatavalid, bus.m1_readdata);
    end
    @(posedge clk); #1;
    bus.s_readdatavalid = 1'b0;
  endtask

  // Randomized traffic: each master holds a request until its waitrequest drops; the slave
  // stalls randomly and returns reads from a reference memory after a random latency.
  task automatic test_random();
    localparam int N = 40;
    bit          pend[2], isrd[2], rdwait[2];
    logic [31:0] paddr[2], pdata[2];
    int          issued[2], done[2];
    logic [31:0] mem[16];
    bit          sl_busy;
    int          sl_cnt, sl_owner, last_done;
    logic [31:0] sl_data;
    bit          prev_arb, prev_any, prev_both, prev_p1;
    logic [1:0]  exp_g;
    bit          acc_m[2];
    bit          s_acc, g, fire;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; isrd[i] = 0; rdwait[i] = 0; issued[i] = 0; done[i] = 0;
      paddr[i] = '0; pdata[i] = '0;
    end
    sl_busy = 0; sl_cnt = 0; sl_owner = 0; sl_data = '0; last_done = 1;
    prev_arb = 0; prev_any = 0; prev_both = 0; prev_p1 = 0;
    do_reset();
    for (int c = 0; c < 5000 && (done[0] < N || done[1] < N); c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && !rdwait[i] && issued[i] < N && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; isrd[i] = $urandom_range(0, 1); issued[i]++;
          paddr[i] = $urandom_range(0, 15); pdata[i] = $urandom;
        end
      end
      bus.m0_read = pend[0] & isrd[0]; bus.m0_write = pend[0] & ~isrd[0];
      bus.m0_address = paddr[0]; bus.m0_writedata = pdata[0];
      bus.m1_read = pend[1] & isrd[1]; bus.m1_write = pend[1] & ~isrd[1];
      bus.m1_address = paddr[1]; bus.m1_writedata = pdata[1];
      fire = sl_busy && sl_cnt == 0;
      bus.s_waitrequest   = $urandom_range(0, 1);
      bus.s_readdatavalid = fire;
      bus.s_readdata      = fire ? sl_data : $urandom;
      #1;
      if (prev_arb && prev_any) begin
        if (prev_both) exp_g = (last_done == 1) ? 2'b01 : 2'b10;
        else           exp_g = prev_p1 ? 2'b10 : 2'b01;
        tests++;
        if (grant !== exp_g) begin
          fails++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, grant, exp_g);
        end
      end
      prev_arb  = (grant == 2'b00);
      prev_any  = pend[0] | pend[1];
      prev_both = pend[0] & pend[1];
      prev_p1   = pend[1];
      acc_m[0] = pend[0] && !bus.m0_waitrequest;
      acc_m[1] = pend[1] && !bus.m1_waitrequest;
      s_acc    = (bus.s_read || bus.s_write) && !bus.s_waitrequest;
      tests++;
      if ((int'(acc_m[0]) + int'(acc_m[1])) !== int'(s_acc)) begin
        fails++;
        $display("FAIL rnd_accept_pair cyc=%0d got m_acc=%b%b s_acc=%b", c, acc_m[1], acc_m[0], s_acc);
      end
      if (s_acc) begin
        g = (grant == 2'b10);
        tests++;
        if (!pend[g] || !acc_m[g] || bus.s_read !== isrd[g] || bus.s_write !== !isrd[g] ||
            bus.s_address !== paddr[g] || (!isrd[g] && bus.s_writedata !== pdata[g])) begin
          fails++;
          $display("FAIL rnd_xfer cyc=%0d m=%0d got rd=%b wr=%b a=%h d=%h exp rd=%b a=%h d=%h",
                   c, g, bus.s_read, bus.s_write, bus.s_address, bus.s_writedata,
                   isrd[g], paddr[g], pdata[g]);
        end
        pend[g] = 0;
        if (isrd[g]) begin
          rdwait[g] = 1; sl_busy = 1; sl_owner = g;
          sl_cnt = $urandom_range(0, 4); sl_data = mem[paddr[g][3:0]];
        end else begin
          mem[paddr[g][3:0]] = pdata[g]; done[g]++; last_done = g;
        end
      end
      if (fire) begin
        tests++;
        if (bus.m0_readdatavalid !== (sl_owner == 0) || bus.m1_readdatavalid !== (sl_owner == 1) ||
            bus.m0_readdata !== sl_data) begin
          fails++;
          $display("FAIL rnd_rdata cyc=%0d got rdv=%b%b d=%h exp owner=%0d d=%h", c,
                   bus.m1_readdatavalid, bus.m0_readdatavalid, bus.m0_readdata, sl_owner, sl_data);
        end
        rdwait[sl_owner] = 0; done[sl_owner]++; last_done = sl_owner; sl_busy = 0;
      end else begin
        tests++;
        if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin
          fails++;
          $display("FAIL rnd_idle_rdv cyc=%0d got=%b%b exp=00", c,
                   bus.m1_readdatavalid, bus.m0_readdatavalid);
        end
        if (sl_busy && !s_acc) sl_cnt--;
      end
    end
    tests++;
    if (done[0] !== N || done[1] !== N) begin
      fails++; $display("FAIL rnd_completed got=%0d/%0d exp=%0d/%0d", done[0], done[1], N, N);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_spurious();
    test_reset_rdwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
